// File: rtl/bit_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : bit_frame_pkg
//  Description : Shared types and helpers for the bit_frame_aligner slice.
//                FSM state encoding, byte width, default sync word and the
//                even-parity helper used when BIT_FRAME_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package bit_frame_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] DEFAULT_SYNC_WORD = 8'hD5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HUNT    = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_e;

   // Even-parity bit for a data byte: XOR of the byte and this bit is 0.
   function automatic logic frame_parity(input logic [BYTE_W-1:0] data);
      return ^data;
   endfunction

endpackage : bit_frame_pkg
`default_nettype wire

// File: rtl/bit_frame_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : bit_frame_out_reg
//  Description : One-entry valid/ready holding register for deserialized
//                bytes. A byte offered while the entry is full and not being
//                accepted is dropped and flagged with a one-cycle overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_frame_out_reg
   import bit_frame_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [BYTE_W-1:0] data_i,
   input  logic              ready_i,
   output logic [BYTE_W-1:0] data_o,
   output logic              valid_o,
   output logic              overflow_o
);

   logic [BYTE_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              overflow_q, overflow_d;

   // Next-state: accept clears the entry, a new byte refills it in the same cycle.
   always_comb begin
      data_d     = data_q;
      valid_d    = valid_q;
      overflow_d = 1'b0;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      if (load_i) begin
         if (!valid_q || ready_i) begin
            data_d  = data_i;
            valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
   end

   // Holding register and overflow pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q     <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign overflow_o = overflow_q;

endmodule : bit_frame_out_reg
`default_nettype wire

// File: rtl/bit_frame_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : bit_frame_aligner
//  Description : Hunts for an 8-bit sync word while upstream lock is held,
//                then deserializes PAYLOAD_BYTES bytes MSB-first into a
//                valid/ready holding register with frame-start, frame-end,
//                sync-error and overflow pulses.
//                Optional macro BIT_FRAME_PARITY_EN adds a 9th even-parity
//                bit after every payload byte and drives parity_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_frame_aligner
   import bit_frame_pkg::*;
#(
   parameter logic [BYTE_W-1:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
   parameter int unsigned       PAYLOAD_BYTES = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              din,
   input  logic              lock_in,
   output logic [BYTE_W-1:0] byte_data,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              frame_start,
   output logic              frame_end,
   output logic              sync_err,
   output logic              overflow,
   output logic              parity_err,
   output logic [1:0]        state
);

`ifdef BIT_FRAME_PARITY_EN
   // The full data byte must sit in sr while the parity bit arrives on din.
   localparam int         c_SR_W     = 8;
   localparam logic [3:0] c_BIT_LAST = 4'd8;
`else
   // Only the seven newest bits are ever read; the eighth arrives on din.
   localparam int         c_SR_W     = 7;
   localparam logic [3:0] c_BIT_LAST = 4'd7;
`endif
   localparam logic [7:0] c_LAST_BYTE = 8'(PAYLOAD_BYTES - 32'd1);
   localparam logic [3:0] c_HCNT_MAX  = 4'd8;

   state_e            state_q, state_d;
   logic [c_SR_W-1:0] sr_q, sr_d;
   logic [3:0]        hcnt_q, hcnt_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        byte_cnt_q, byte_cnt_d;
   logic              frame_start_q, frame_start_d;
   logic              frame_end_q, frame_end_d;
   logic              sync_err_q, sync_err_d;
   logic              parity_err_d;
   logic              w_byte_done;
   logic [BYTE_W-1:0] w_byte;
   logic [BYTE_W-1:0] w_window;

   // Newest eight stream bits including the one currently on din.
   assign w_window = {sr_q[6:0], din};

`ifdef BIT_FRAME_PARITY_EN
   assign w_byte = sr_q;
`else
   assign w_byte = w_window;
`endif

   // Next-state logic: lock loss overrides everything, then hunt/payload.
   always_comb begin
      state_d       = state_q;
      sr_d          = sr_q;
      hcnt_d        = hcnt_q;
      bit_cnt_d     = bit_cnt_q;
      byte_cnt_d    = byte_cnt_q;
      frame_start_d = 1'b0;
      frame_end_d   = 1'b0;
      sync_err_d    = 1'b0;
      parity_err_d  = 1'b0;
      w_byte_done   = 1'b0;

      if (en && (state_q != ST_IDLE)) begin
         sr_d = {sr_q[c_SR_W-2:0], din};
      end

      if (!lock_in) begin
         sync_err_d = (state_q == ST_PAYLOAD);
         state_d    = ST_IDLE;
         hcnt_d     = '0;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_HUNT;
               hcnt_d  = '0;
            end
            ST_HUNT: begin
               if (en) begin
                  // hcnt >= 7 guarantees all eight window bits are from this visit.
                  if ((hcnt_q >= 4'd7) && (w_window == SYNC_WORD)) begin
                     state_d       = ST_PAYLOAD;
                     bit_cnt_d     = '0;
                     byte_cnt_d    = '0;
                     frame_start_d = 1'b1;
                  end else if (hcnt_q != c_HCNT_MAX) begin
                     hcnt_d = hcnt_q + 4'd1;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (en) begin
                  if (bit_cnt_q == c_BIT_LAST) begin
                     w_byte_done = 1'b1;
                     bit_cnt_d   = '0;
`ifdef BIT_FRAME_PARITY_EN
                     parity_err_d = (frame_parity(sr_q) != din);
`endif
                     if (byte_cnt_q == c_LAST_BYTE) begin
                        frame_end_d = 1'b1;
                        state_d     = ST_HUNT;
                        hcnt_d      = '0;
                        byte_cnt_d  = '0;
                     end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, shift register, counters and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         sr_q          <= '0;
         hcnt_q        <= '0;
         bit_cnt_q     <= '0;
         byte_cnt_q    <= '0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
         sync_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_d;
         hcnt_q        <= hcnt_d;
         bit_cnt_q     <= bit_cnt_d;
         byte_cnt_q    <= byte_cnt_d;
         frame_start_q <= frame_start_d;
         frame_end_q   <= frame_end_d;
         sync_err_q    <= sync_err_d;
      end
   end

`ifdef BIT_FRAME_PARITY_EN
   logic parity_err_q;

   // Parity mismatch pulse, aligned with the byte's valid rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`else
   logic w_parity_unused;
   assign w_parity_unused = parity_err_d;
   assign parity_err      = 1'b0;
`endif

   bit_frame_out_reg u_out_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (w_byte_done),
      .data_i     (w_byte),
      .ready_i    (byte_ready),
      .data_o     (byte_data),
      .valid_o    (byte_valid),
      .overflow_o (overflow)
   );

   assign frame_start = frame_start_q;
   assign frame_end   = frame_end_q;
   assign sync_err    = sync_err_q;
   assign state       = state_q;

endmodule : bit_frame_aligner
`default_nettype wire

// File: tb/tb_bit_frame_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bit_frame_aligner
//  Description : Self-checking bench for bit_frame_aligner. A table of whole
//                frames is replayed, followed by hand-written sequences for
//                back-pressure, lock loss, fresh-bit hunting and parity.
//                Honours BIT_FRAME_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_frame_aligner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       din;
   logic       lock_in;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       byte_ready;
   logic       frame_start;
   logic       frame_end;
   logic       sync_err;
   logic       overflow;
   logic       parity_err;
   logic [1:0] state;

   bit_frame_aligner dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .din         (din),
      .lock_in     (lock_in),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .frame_start (frame_start),
      .frame_end   (frame_end),
      .sync_err    (sync_err),
      .overflow    (overflow),
      .parity_err  (parity_err),
      .state       (state)
   );

   always #5 clk = ~clk;

   // Event monitor, sampled on the falling edge.
   int         cyc = 0;
   int         fs_cnt = 0, fe_cnt = 0, ov_cnt = 0, se_cnt = 0;
   int         pe_cnt = 0, pe_valid_cnt = 0;
   int         fe_cyc = 0;
   logic [7:0] fe_byte = 8'h00;
   logic       fe_valid = 1'b0;
   logic [7:0] got[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_start) fs_cnt <= fs_cnt + 1;
      if (frame_end) begin
         fe_cnt   <= fe_cnt + 1;
         fe_cyc   <= cyc;
         fe_byte  <= byte_data;
         fe_valid <= byte_valid;
      end
      if (overflow) ov_cnt <= ov_cnt + 1;
      if (sync_err) se_cnt <= se_cnt + 1;
      if (parity_err) pe_cnt <= pe_cnt + 1;
      if (parity_err && byte_valid) pe_valid_cnt <= pe_valid_cnt + 1;
      if (byte_valid && byte_ready) got.push_back(byte_data);
   end

   int n_checks = 0;
   int n_errs   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

`ifdef BIT_FRAME_PARITY_EN
   logic par_flip = 1'b0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input int gap);
      en  = 1'b1;
      din = b;
      tick();
      en  = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int i = 7; i >= 0; i--) send_bit(b[i], gap);
`ifdef BIT_FRAME_PARITY_EN
      send_bit((^b) ^ par_flip, gap);
      par_flip = 1'b0;
`endif
   endtask

   task automatic send_frame(input logic [31:0] payload, input int gap);
      send_byte(8'hD5, gap);
      for (int k = 0; k < 4; k++) send_byte(payload[31-8*k -: 8], gap);
   endtask

   task automatic restart();
      lock_in = 1'b0;
      en      = 1'b0;
      tick();
      check("idle_on_unlock", {30'd0, state}, 32'd0);
      lock_in = 1'b1;
      tick();
      check("hunt_on_lock", {30'd0, state}, 32'd1);
   endtask

   typedef struct {
      logic [31:0] payload;
      int          gap;
      logic [31:0] exp_bytes;
      int          exp_fe_cyc;
   } vec_t;

`ifdef BIT_FRAME_PARITY_EN
   localparam int c_CYC_FULL = 44;
   localparam int c_CYC_HALF = 87;
`else
   localparam int c_CYC_FULL = 40;
   localparam int c_CYC_HALF = 79;
`endif

   vec_t tbl[4];

   initial begin
      int start, fs0, fe0, ov0, se0, pe0, pv0, g0;

      tbl[0] = '{32'h12345678, 0, 32'h12345678, c_CYC_FULL};
      tbl[1] = '{32'h12345678, 1, 32'h12345678, c_CYC_HALF};
      tbl[2] = '{32'hD5D5D5D5, 0, 32'hD5D5D5D5, c_CYC_FULL};
      tbl[3] = '{32'hFF00A53C, 0, 32'hFF00A53C, c_CYC_FULL};

      rst_n = 1'b0; lock_in = 1'b1; en = 1'b0; din = 1'b0; byte_ready = 1'b1;
      repeat (3) tick();
      check("rst_state",       {30'd0, state}, 32'd0);
      check("rst_byte_data",   {24'd0, byte_data}, 32'd0);
      check("rst_byte_valid",  {31'd0, byte_valid}, 32'd0);
      check("rst_frame_start", {31'd0, frame_start}, 32'd0);
      check("rst_frame_end",   {31'd0, frame_end}, 32'd0);
      check("rst_overflow",    {31'd0, overflow}, 32'd0);
      check("rst_sync_err",    {31'd0, sync_err}, 32'd0);
      check("rst_parity_err",  {31'd0, parity_err}, 32'd0);
      rst_n = 1'b1;
      tick();
      check("hunt_after_reset", {30'd0, state}, 32'd1);

      // Table of complete frames.
      for (int v = 0; v < 4; v++) begin
         restart();
         fs0 = fs_cnt; fe0 = fe_cnt; ov0 = ov_cnt; g0 = got.size();
         start = cyc;
         send_frame(tbl[v].payload, tbl[v].gap);
         repeat (3) tick();
         check("frame_start_count", fs_cnt - fs0, 1);
         check("frame_end_count",   fe_cnt - fe0, 1);
         check("frame_end_latency", fe_cyc - start, tbl[v].exp_fe_cyc);
         check("frame_end_byte",    {24'd0, fe_byte}, {24'd0, tbl[v].exp_bytes[7:0]});
         check("frame_end_valid",   {31'd0, fe_valid}, 32'd1);
         check("byte_count",        got.size() - g0, 4);
         if (got.size() - g0 == 4) begin
            for (int k = 0; k < 4; k++)
               check("byte_value", {24'd0, got[g0+k]}, {24'd0, tbl[v].exp_bytes[31-8*k -: 8]});
         end
         check("no_overflow",       ov_cnt - ov0, 0);
         check("state_back_hunt",   {30'd0, state}, 32'd1);
      end

      // Back-pressure through a whole frame.
      restart();
      byte_ready = 1'b0;
      ov0 = ov_cnt; fe0 = fe_cnt; g0 = got.size();
      send_frame(32'h12345678, 0);
      repeat (3) tick();
      check("bp_overflow_count", ov_cnt - ov0, 3);
      check("bp_frame_end",      fe_cnt - fe0, 1);
      check("bp_fe_byte",        {24'd0, fe_byte}, 32'h12);
      check("bp_held_data",      {24'd0, byte_data}, 32'h12);
      check("bp_held_valid",     {31'd0, byte_valid}, 32'd1);
      check("bp_no_accept",      got.size() - g0, 0);
      byte_ready = 1'b1;
      repeat (3) tick();
      check("bp_deliver_once",   got.size() - g0, 1);
      if (got.size() - g0 == 1) check("bp_deliver_value", {24'd0, got[g0]}, 32'h12);
      check("bp_valid_cleared",  {31'd0, byte_valid}, 32'd0);

      // Lock loss after twelve payload bits.
      restart();
      se0 = se_cnt; g0 = got.size();
      send_byte(8'hD5, 0);
      send_byte(8'h12, 0);
      send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
`ifndef BIT_FRAME_PARITY_EN
      send_bit(1'b1, 0);
`endif
      lock_in = 1'b0;
      repeat (2) tick();
      check("ll_state_idle", {30'd0, state}, 32'd0);
      for (int i = 0; i < 8; i++) send_bit(i[0], 0);
      repeat (3) tick();
      check("ll_sync_err_count", se_cnt - se0, 1);
      check("ll_one_byte",       got.size() - g0, 1);
      if (got.size() - g0 == 1) check("ll_byte_value", {24'd0, got[g0]}, 32'h12);
      lock_in = 1'b1;

      // Stale shift-register bits must not complete a match.
      restart();
      send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      restart();
      fs0 = fs_cnt;
      send_bit(1'b0, 0); send_bit(1'b1, 0);
      repeat (2) tick();
      check("fresh_no_stale_match", fs_cnt - fs0, 0);
      send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      repeat (2) tick();
      check("fresh_no_early_match", fs_cnt - fs0, 0);
      send_bit(1'b1, 0);
      repeat (2) tick();
      check("fresh_match",         fs_cnt - fs0, 1);
      check("fresh_state_payload", {30'd0, state}, 32'd2);
      restart();

`ifdef BIT_FRAME_PARITY_EN
      // Wrong parity bit on the first payload byte.
      pe0 = pe_cnt; pv0 = pe_valid_cnt; g0 = got.size();
      par_flip = 1'b1;
      send_frame(32'h12345678, 0);
      repeat (3) tick();
      check("par_err_count",      pe_cnt - pe0, 1);
      check("par_err_with_valid", pe_valid_cnt - pv0, 1);
      check("par_byte_count",     got.size() - g0, 4);
      if (got.size() - g0 == 4) check("par_byte_value", {24'd0, got[g0]}, 32'h12);
`else
      pe0 = 0; pv0 = 0;
      check("parity_err_never", pe_cnt + pe0, 0);
      check("parity_err_never_valid", pe_valid_cnt + pv0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_bit_frame_aligner
`default_nettype wire
